// File: rtl/mul_div_unit_pkg.sv
// Shared op encodings and FSM state encodings for the multiply/divide unit.
// The state encodings are also consumed by the hazard unit for debug visibility.
package mul_div_unit_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] ALU_OP_MUL  = 5'd12;
  localparam logic [OP_W-1:0] ALU_OP_MULU = 5'd13;
  localparam logic [OP_W-1:0] ALU_OP_DIV  = 5'd14;
  localparam logic [OP_W-1:0] ALU_OP_DIVU = 5'd15;
  localparam logic [OP_W-1:0] ALU_OP_MTHI = 5'd16;
  localparam logic [OP_W-1:0] ALU_OP_MTLO = 5'd17;

  typedef enum logic [1:0] {
    MDU_IDLE  = 2'd0,
    MDU_CALC  = 2'd1,
    MDU_FIXUP = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mul_div_unit_step.sv
// One iteration of radix-2 shift-add multiply or restoring divide on
// unsigned magnitudes; the top iterates this DATA_WIDTH times.
module mul_div_step #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_is_div,
  input  logic [DATA_WIDTH-1:0] i_acc,
  input  logic [DATA_WIDTH-1:0] i_q,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_acc,
  output logic [DATA_WIDTH-1:0] o_q
);

  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH:0]   w_rsh;
  logic [DATA_WIDTH-1:0] w_diff;
  logic                  w_ge;

  assign w_sum  = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_b} : (DATA_WIDTH+1)'(0));
  assign w_rsh  = {i_acc, i_q[DATA_WIDTH-1]};
  assign w_ge   = (w_rsh >= {1'b0, i_b});
  // A successful subtract always leaves a result below the divisor, so W bits suffice.
  assign w_diff = w_rsh[DATA_WIDTH-1:0] - i_b;

  always_comb begin
    o_acc = w_sum[DATA_WIDTH:1];
    o_q   = {w_sum[0], i_q[DATA_WIDTH-1:1]};
    if (i_is_div) begin
      o_acc = w_ge ? w_diff : w_rsh[DATA_WIDTH-1:0];
      o_q   = {i_q[DATA_WIDTH-2:0], w_ge};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Fixed latency of DATA_WIDTH+1 edges from acceptance to HI/LO update.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ALU_OP_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ALU_OP_WIDTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]   rs,
  input  logic [DATA_WIDTH-1:0]   rt,
  input  logic                    stall,
  input  logic                    flush,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   hi,
  output logic [DATA_WIDTH-1:0]   lo
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  mdu_state_e            r_state, w_state_n;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_acc, r_q, r_b, r_hi, r_lo;
  logic                  r_is_div, r_neg_res, r_neg_rem, r_dz, r_done;

  logic                    w_is_mul, w_is_div, w_signed, w_accept, w_start_md, w_fix_write;
  logic [DATA_WIDTH-1:0]   w_a_abs, w_b_abs, w_acc_n, w_q_n, w_quo, w_rem;
  logic [2*DATA_WIDTH-1:0] w_prod, w_prod_fix;

  assign w_is_mul   = (op == ALU_OP_WIDTH'(ALU_OP_MUL)) || (op == ALU_OP_WIDTH'(ALU_OP_MULU));
  assign w_is_div   = (op == ALU_OP_WIDTH'(ALU_OP_DIV)) || (op == ALU_OP_WIDTH'(ALU_OP_DIVU));
  assign w_signed   = (op == ALU_OP_WIDTH'(ALU_OP_MUL)) || (op == ALU_OP_WIDTH'(ALU_OP_DIV));
  assign w_accept   = start && !stall && !flush && (r_state == MDU_IDLE);
  assign w_start_md = w_accept && (w_is_mul || w_is_div);
  assign w_a_abs    = (w_signed && rs[DATA_WIDTH-1]) ? -rs : rs;
  assign w_b_abs    = (w_signed && rt[DATA_WIDTH-1]) ? -rt : rt;

  mul_div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_q      (r_q),
    .i_b      (r_b),
    .o_acc    (w_acc_n),
    .o_q      (w_q_n)
  );

  // Sign fixup on the unsigned magnitude results
  assign w_prod     = {r_acc, r_q};
  assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
  assign w_quo      = r_dz ? '1 : (r_neg_res ? -r_q : r_q);
  assign w_rem      = r_neg_rem ? -r_acc : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MDU_IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n   = r_state;
    w_fix_write = 1'b0;
    case (r_state)
      MDU_IDLE:  if (w_start_md) w_state_n = MDU_CALC;
      MDU_CALC: begin
        if (flush)                     w_state_n = MDU_IDLE;
        else if (r_cnt == CNT_W'(1))   w_state_n = MDU_FIXUP;
      end
      MDU_FIXUP: begin
        w_state_n   = MDU_IDLE;
        w_fix_write = !flush;
      end
      default:   w_state_n = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_b       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dz      <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_fix_write;
      if (w_start_md) begin
        r_is_div  <= w_is_div;
        r_neg_res <= w_signed && (rs[DATA_WIDTH-1] ^ rt[DATA_WIDTH-1]);
        r_neg_rem <= w_signed && w_is_div && rs[DATA_WIDTH-1];
        r_dz      <= (rt == '0);
        r_cnt     <= CNT_W'(DATA_WIDTH);
        r_acc     <= '0;
        r_q       <= w_a_abs;
        r_b       <= w_b_abs;
      end else if (r_state == MDU_CALC) begin
        r_acc <= w_acc_n;
        r_q   <= w_q_n;
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_accept && (op == ALU_OP_WIDTH'(ALU_OP_MTHI))) r_hi <= rs;
      if (w_accept && (op == ALU_OP_WIDTH'(ALU_OP_MTLO))) r_lo <= rs;
      if (w_fix_write) begin
        if (r_is_div) begin
          r_hi <= w_rem;
          r_lo <= w_quo;
        end else begin
          {r_hi, r_lo} <= w_prod_fix;
        end
      end
    end
  end

  assign busy = (r_state != MDU_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit at DATA_WIDTH=32.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk, rst_n, start, stall, flush;
  logic [4:0]  op;
  logic [31:0] rs, rt;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  mul_div_unit #(.DATA_WIDTH(32), .ALU_OP_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs(rs), .rt(rt),
    .stall(stall), .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one MUL*/DIV* and report latency in edges and cycles seen busy.
  task automatic run_md(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    busy_cnt = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0;
    op = '0; rs = '0; rt = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mulu_max();
    int lat, bc;
    run_md(ALU_OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL mulu_latency: got %0d expected 33", lat); end
    checks++;
    if (bc !== 33) begin failures++; $display("FAIL mulu_busy_cycles: got %0d expected 33", bc); end
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      failures++; $display("FAIL mulu_max: hi=%h lo=%h expected fffffffe 00000001", hi, lo);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL done_pulse_width: done=%b expected 0", done); end
  endtask

  task automatic test_mul_signed();
    int lat, bc;
    run_md(ALU_OP_MUL, 32'hFFFF_FFF9, 32'd3, lat, bc);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
      failures++; $display("FAIL mul_neg7x3: hi=%h lo=%h expected ffffffff ffffffeb", hi, lo);
    end
    run_md(ALU_OP_MULU, 32'h1234_5678, 32'h0000_0100, lat, bc);
    checks++;
    if (hi !== 32'h0000_0012 || lo !== 32'h3456_7800) begin
      failures++; $display("FAIL mulu_shift: hi=%h lo=%h expected 00000012 34567800", hi, lo);
    end
  endtask

  task automatic test_div();
    int lat, bc;
    run_md(ALU_OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bc);
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL div_neg7_2: lo=%h hi=%h expected fffffffd ffffffff", lo, hi);
    end
    run_md(ALU_OP_DIV, 32'd7, 32'hFFFF_FFFE, lat, bc);
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'h0000_0001) begin
      failures++; $display("FAIL div_7_neg2: lo=%h hi=%h expected fffffffd 00000001", lo, hi);
    end
    run_md(ALU_OP_DIVU, 32'd100, 32'd7, lat, bc);
    checks++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      failures++; $display("FAIL divu_100_7: lo=%0d hi=%0d expected 14 2", lo, hi);
    end
  endtask

  task automatic test_div_corner();
    int lat, bc;
    run_md(ALU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    checks++;
    if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
      failures++; $display("FAIL div_overflow: lo=%h hi=%h expected 80000000 00000000", lo, hi);
    end
    run_md(ALU_OP_DIVU, 32'd5, 32'd0, lat, bc);
    checks++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'd5) begin
      failures++; $display("FAIL divu_by_zero: lo=%h hi=%h expected ffffffff 00000005", lo, hi);
    end
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL div0_latency: got %0d expected 33", lat); end
    run_md(ALU_OP_DIV, 32'hFFFF_FFFB, 32'd0, lat, bc);
    checks++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFFB) begin
      failures++; $display("FAIL div_neg_by_zero: lo=%h hi=%h expected ffffffff fffffffb", lo, hi);
    end
  endtask

  task automatic test_mt_flush();
    bit saw_done;
    @(negedge clk);
    start = 1'b1; op = ALU_OP_MTHI; rs = 32'h0000_1234;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    checks++;
    if (hi !== 32'h0000_1234 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL mthi: hi=%h busy=%b done=%b expected 00001234 0 0", hi, busy, done);
    end
    start = 1'b1; op = ALU_OP_MTLO; rs = 32'h0000_5678;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    checks++;
    if (lo !== 32'h0000_5678 || busy !== 1'b0) begin
      failures++; $display("FAIL mtlo: lo=%h busy=%b expected 00005678 0", lo, busy);
    end
    // Flush in IDLE and stall both block acceptance
    start = 1'b1; op = ALU_OP_MTHI; rs = 32'hBEEF; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; stall = 1'b1; op = ALU_OP_MULU; rs = 32'd3; rt = 32'd5;
    @(posedge clk); #1 start = 1'b0; stall = 1'b0;
    @(negedge clk);
    checks++;
    if (hi !== 32'h0000_1234 || busy !== 1'b0) begin
      failures++; $display("FAIL flush_stall_idle: hi=%h busy=%b expected 00001234 0", hi, busy);
    end
    // MULU, ignored second start at cycle 5, flush at cycle 10
    start = 1'b1; op = ALU_OP_MULU; rs = 32'd3; rt = 32'd5;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = ALU_OP_MTLO; rs = 32'hDEAD;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || lo !== 32'h0000_5678) begin
      failures++; $display("FAIL start_while_busy: busy=%b lo=%h expected 1 00005678", busy, lo);
    end
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0000_1234 || lo !== 32'h0000_5678) begin
      failures++; $display("FAIL flush_calc: busy=%b hi=%h lo=%h expected 0 00001234 00005678", busy, hi, lo);
    end
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || lo !== 32'h0000_5678) begin
      failures++; $display("FAIL flush_no_done: done_seen=%b lo=%h expected 0 00005678", saw_done, lo);
    end
  endtask

  task automatic test_async_reset();
    int lat, bc;
    @(negedge clk);
    start = 1'b1; op = ALU_OP_MULU; rs = 32'hFFFF_FFFF; rt = 32'h7;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      failures++; $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_md(ALU_OP_MULU, 32'd3, 32'd4, lat, bc);
    checks++;
    if (lo !== 32'd12 || hi !== 32'd0 || lat !== 33) begin
      failures++; $display("FAIL post_reset_mulu: lo=%0d hi=%0d lat=%0d expected 12 0 33", lo, hi, lat);
    end
  endtask

  initial begin
    test_reset();
    test_mulu_max();
    test_mul_signed();
    test_div();
    test_div_corner();
    test_mt_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
